// File: rtl/qam_tx_pkg.sv
// Shared definitions for the QAM transmit path: oversampling ratio, FSM state
// encoding, pulse-shaping tap table and mapper-code-to-level decode.
package qam_tx_pkg;

   localparam int TX_OSR = 4;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   // 16-tap raised-cosine-like pulse, read polyphase as TAPS[4*k + phase]
   localparam logic signed [7:0] TAPS [16] = '{
      -8'sd2, -8'sd5, -8'sd6,  8'sd0,  8'sd14, 8'sd37, 8'sd63, 8'sd82,
       8'sd82, 8'sd63, 8'sd37, 8'sd14, 8'sd0, -8'sd6, -8'sd5, -8'sd2
   };

   function automatic logic signed [2:0] decode_level(input logic [1:0] code);
      logic signed [2:0] lvl;
      lvl = '0;
      case (code)
         2'b00:   lvl = -3'sd3;
         2'b01:   lvl = -3'sd1;
         2'b11:   lvl =  3'sd1;
         default: lvl =  3'sd3;
      endcase
      return lvl;
   endfunction

endpackage

// File: rtl/qam_polyphase_mac.sv
// One rail of the polyphase pulse shaper: selects the four taps belonging to
// the given phase and accumulates them against the four most recent levels.
module qam_polyphase_mac
   import qam_tx_pkg::*;
(
   input  logic signed [2:0]  x0_i,
   input  logic signed [2:0]  x1_i,
   input  logic signed [2:0]  x2_i,
   input  logic signed [2:0]  x3_i,
   input  logic        [1:0]  phase_i,
   output logic signed [11:0] y_o
);

   logic signed [2:0]  lvl [4];
   logic signed [10:0] prod;
   logic signed [11:0] acc;
   logic        [3:0]  idx;

   assign lvl[0] = x0_i;
   assign lvl[1] = x1_i;
   assign lvl[2] = x2_i;
   assign lvl[3] = x3_i;

   // Tap index 4k+p is just {k, p} because OSR is 4
   always_comb begin
      acc  = '0;
      prod = '0;
      idx  = '0;
      for (int k = 0; k < 4; k++) begin
         idx  = {2'(k), phase_i};
         prod = 11'(TAPS[idx]) * 11'(lvl[k]);
         acc  = acc + 12'(prod);
      end
   end

   assign y_o = acc;

endmodule

// File: rtl/qam_pulse_shaper.sv
// Oversampling QAM pulse shaper: accepts one I/Q symbol per OSR cycles and
// emits OSR filtered samples per symbol, starting the cycle after acceptance.
module qam_pulse_shaper
   import qam_tx_pkg::*;
#(
   parameter int OSR = 4,
   parameter int OW  = 12
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 en,
   input  logic                 sym_valid,
   output logic                 sym_ready,
   input  logic [1:0]           I_in,
   input  logic [1:0]           Q_in,
   output logic signed [OW-1:0] I_out,
   output logic signed [OW-1:0] Q_out,
   output logic                 out_valid
);

   localparam logic [1:0] LAST_PHASE = 2'(OSR - 1);

   state_t            state_q, state_d;
   logic [1:0]        phase_q, phase_d;
   logic signed [2:0] histI_q [4];
   logic signed [2:0] histI_d [4];
   logic signed [2:0] histQ_q [4];
   logic signed [2:0] histQ_d [4];
   logic              accept;
   logic signed [11:0] yI, yQ;
   logic              outValid_d;
   logic signed [OW-1:0] iOut_d, qOut_d;

   assign sym_ready = en && ((state_q == IDLE) || (phase_q == LAST_PHASE));
   assign accept    = sym_valid && sym_ready;

   always_comb begin
      state_d = state_q;
      phase_d = phase_q;
      histI_d = histI_q;
      histQ_d = histQ_q;
      if (accept) begin
         histI_d[3] = histI_q[2];
         histI_d[2] = histI_q[1];
         histI_d[1] = histI_q[0];
         histI_d[0] = decode_level(I_in);
         histQ_d[3] = histQ_q[2];
         histQ_d[2] = histQ_q[1];
         histQ_d[1] = histQ_q[0];
         histQ_d[0] = decode_level(Q_in);
         state_d    = RUN;
         phase_d    = '0;
      end else if (state_q == RUN) begin
         phase_d = phase_q + 2'd1;
         if (phase_q == LAST_PHASE) begin
            state_d = IDLE;
         end
      end
   end

   // The MACs see next-state history and phase so each sample lands in the
   // output register on the same edge that enters its phase.
   qam_polyphase_mac u_macI (
      .x0_i   (histI_d[0]),
      .x1_i   (histI_d[1]),
      .x2_i   (histI_d[2]),
      .x3_i   (histI_d[3]),
      .phase_i(phase_d),
      .y_o    (yI)
   );

   qam_polyphase_mac u_macQ (
      .x0_i   (histQ_d[0]),
      .x1_i   (histQ_d[1]),
      .x2_i   (histQ_d[2]),
      .x3_i   (histQ_d[3]),
      .phase_i(phase_d),
      .y_o    (yQ)
   );

   always_comb begin
      outValid_d = (state_d == RUN);
      iOut_d     = '0;
      qOut_d     = '0;
      if (outValid_d) begin
         iOut_d = OW'(yI);
         qOut_d = OW'(yQ);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         phase_q   <= '0;
         histI_q   <= '{default: '0};
         histQ_q   <= '{default: '0};
         I_out     <= '0;
         Q_out     <= '0;
         out_valid <= 1'b0;
      end else begin
         state_q   <= state_d;
         phase_q   <= phase_d;
         histI_q   <= histI_d;
         histQ_q   <= histQ_d;
         I_out     <= iOut_d;
         Q_out     <= qOut_d;
         out_valid <= outValid_d;
      end
   end

endmodule
